// File: rtl/reg_file_sb.sv
// Parametrised register file with optional x0, write-to-read bypass and a
// busy-bit scoreboard used by the pipeline hazard logic.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       WE3,
  input  logic [ADDR_W-1:0]          A3,
  input  logic [DATA_W-1:0]          WD3,
  input  logic [NUM_RD*ADDR_W-1:0]   RA,
  output logic [NUM_RD*DATA_W-1:0]   RD,
  input  logic                       claim_en,
  input  logic [ADDR_W-1:0]          claim_addr,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic [(2**ADDR_W)-1:0]     busy_vec,
  output logic [ADDR_W:0]            pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   pend_q, pend_d;
  logic              wr_legal;
  logic              claim_legal;

  assign wr_legal    = WE3 && ((A3 != '0) || (ZERO_REG == 0));
  assign claim_legal = claim_en && ((claim_addr != '0) || (ZERO_REG == 0));

  // A claim is applied after the clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wr_legal) busy_d[A3] = 1'b0;
    if (claim_legal) busy_d[claim_addr] = 1'b1;
    pend_d = '0;
    for (int n = 0; n < DEPTH; n++) begin
      pend_d = pend_d + {{ADDR_W{1'b0}}, busy_d[n]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) regs_q[n] <= '0;
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      if (wr_legal) regs_q[A3] <= WD3;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  // Read ports: x0 forcing beats bypass, bypass beats array data; reset blanks all.
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd_v;
  logic              bsy_v;

  always_comb begin
    RD      = '0;
    rd_busy = '0;
    ra      = '0;
    rd_v    = '0;
    bsy_v   = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra    = RA[i*ADDR_W +: ADDR_W];
      rd_v  = regs_q[ra];
      bsy_v = busy_q[ra];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_v  = '0;
        bsy_v = 1'b0;
      end else if ((BYPASS != 0) && wr_legal && (A3 == ra)) begin
        rd_v  = WD3;
        bsy_v = 1'b0;
      end
      if (rst) begin
        rd_v  = '0;
        bsy_v = 1'b0;
      end
      RD[i*DATA_W +: DATA_W] = rd_v;
      rd_busy[i]             = bsy_v;
    end
  end

  assign busy_vec = busy_q;
  assign pend_cnt = pend_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default config, no-bypass/no-x0 config,
// and a 3-port 16x16 config, all sharing one clock and reset.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: defaults (32x32, 2 ports, x0 zero, bypass)
  logic        a_we, a_claim;
  logic [4:0]  a_a3, a_caddr;
  logic [31:0] a_wd;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic [1:0]  a_rdb;
  logic [31:0] a_bv;
  logic [5:0]  a_pc;

  // Instance B: no bypass, x0 is ordinary storage
  logic        b_we, b_claim;
  logic [4:0]  b_a3, b_caddr;
  logic [31:0] b_wd;
  logic [9:0]  b_ra;
  logic [63:0] b_rd;
  logic [1:0]  b_rdb;
  logic [31:0] b_bv;
  logic [5:0]  b_pc;

  // Instance C: 16 registers of 16 bits, 3 read ports
  logic        c_we, c_claim;
  logic [3:0]  c_a3, c_caddr;
  logic [15:0] c_wd;
  logic [11:0] c_ra;
  logic [47:0] c_rd;
  logic [2:0]  c_rdb;
  logic [15:0] c_bv;
  logic [4:0]  c_pc;

  reg_file_sb u_a (
    .clk(clk), .rst(rst), .WE3(a_we), .A3(a_a3), .WD3(a_wd), .RA(a_ra), .RD(a_rd),
    .claim_en(a_claim), .claim_addr(a_caddr), .rd_busy(a_rdb), .busy_vec(a_bv), .pend_cnt(a_pc)
  );

  reg_file_sb #(.BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .WE3(b_we), .A3(b_a3), .WD3(b_wd), .RA(b_ra), .RD(b_rd),
    .claim_en(b_claim), .claim_addr(b_caddr), .rd_busy(b_rdb), .busy_vec(b_bv), .pend_cnt(b_pc)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3)) u_c (
    .clk(clk), .rst(rst), .WE3(c_we), .A3(c_a3), .WD3(c_wd), .RA(c_ra), .RD(c_rd),
    .claim_en(c_claim), .claim_addr(c_caddr), .rd_busy(c_rdb), .busy_vec(c_bv), .pend_cnt(c_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  r0, r1, r2;
    logic [15:0] e0, e1, e2;

    rst = 1'b1;
    a_we = 0; a_claim = 0; a_a3 = 0; a_caddr = 0; a_wd = 0; a_ra = 0;
    b_we = 0; b_claim = 0; b_a3 = 0; b_caddr = 0; b_wd = 0; b_ra = 0;
    c_we = 0; c_claim = 0; c_a3 = 0; c_caddr = 0; c_wd = 0; c_ra = 0;

    // Reset state; a write presented during reset must not be forwarded
    #2;
    a_we = 1; a_a3 = 5; a_wd = 32'hDEADBEEF; a_ra = {5'd0, 5'd5};
    #1;
    check("rst_rd", a_rd, 64'h0);
    check("rst_rdb", a_rdb, 2'b00);
    check("rst_bv", a_bv, 32'h0);
    check("rst_pc", a_pc, 6'd0);
    a_we = 0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_after_x5", a_rd[31:0], 32'h0);

    // Same-cycle write/read of x5: A forwards, B shows the old value
    a_we = 1; a_a3 = 5; a_wd = 32'hDEADBEEF; a_ra = {5'd0, 5'd5};
    b_we = 1; b_a3 = 5; b_wd = 32'hDEADBEEF; b_ra = {5'd0, 5'd5};
    #1;
    check("a_bypass_rd0", a_rd[31:0], 32'hDEADBEEF);
    check("a_bypass_rd1_x0", a_rd[63:32], 32'h0);
    check("b_nobypass_rd0", b_rd[31:0], 32'h0);
    tick();
    a_we = 0; b_we = 0;
    #1;
    check("a_x5_after", a_rd[31:0], 32'hDEADBEEF);
    check("b_x5_after", b_rd[31:0], 32'hDEADBEEF);
    check("a_write_nonbusy_bv", a_bv, 32'h0);

    // Write and claim x0
    a_we = 1; a_a3 = 0; a_wd = 32'h12345678; a_claim = 1; a_caddr = 0; a_ra = {5'd0, 5'd0};
    b_we = 1; b_a3 = 0; b_wd = 32'h12345678; b_claim = 1; b_caddr = 0; b_ra = {5'd0, 5'd0};
    #1;
    check("a_x0_bypass_blocked", a_rd, 64'h0);
    tick();
    a_we = 0; a_claim = 0; b_we = 0; b_claim = 0;
    #1;
    check("a_x0_rd", a_rd[31:0], 32'h0);
    check("a_x0_bv", a_bv[0], 1'b0);
    check("a_x0_pc", a_pc, 6'd0);
    check("b_x0_rd", b_rd[31:0], 32'h12345678);
    check("b_x0_bv", b_bv, 32'h1);
    check("b_x0_pc", b_pc, 6'd1);
    check("b_x0_rdb", b_rdb, 2'b11);

    // Claim x7 then x9
    a_claim = 1; a_caddr = 7;
    tick();
    a_caddr = 9;
    tick();
    a_claim = 0; a_ra = {5'd9, 5'd7};
    #1;
    check("sb_pc2", a_pc, 6'd2);
    check("sb_bv", a_bv, 32'h0000_0280);
    check("sb_rdb", a_rdb, 2'b11);

    // Write x7 retires its producer; bypass suppresses the stall this cycle
    a_we = 1; a_a3 = 7; a_wd = 32'h55;
    #1;
    check("wr7_rdb_cycle", a_rdb, 2'b10);
    check("wr7_rd0_cycle", a_rd[31:0], 32'h55);
    tick();
    a_we = 0;
    #1;
    check("wr7_bv", a_bv, 32'h0000_0200);
    check("wr7_pc", a_pc, 6'd1);
    check("wr7_rdb", a_rdb, 2'b10);

    // Claim x3, then claim and write x3 together: the bit must stay set
    a_claim = 1; a_caddr = 3;
    tick();
    a_we = 1; a_a3 = 3; a_wd = 32'hABCD; a_ra = {5'd3, 5'd3};
    #1;
    check("x3_same_rdb_cycle", a_rdb, 2'b00);
    check("x3_same_rd_cycle", a_rd, {32'hABCD, 32'hABCD});
    tick();
    a_we = 0; a_claim = 0;
    #1;
    check("x3_bv", a_bv, 32'h0000_0208);
    check("x3_pc", a_pc, 6'd2);
    check("x3_rdb", a_rdb, 2'b11);
    check("x3_rd", a_rd, {32'hABCD, 32'hABCD});

    // Instance C: fill with 0xA000+n
    for (int n = 0; n < 16; n++) begin
      c_we = 1; c_a3 = 4'(n); c_wd = 16'hA000 + 16'(n);
      tick();
    end
    c_we = 0;
    for (int k = 0; k < 8; k++) begin
      r0 = 4'($urandom_range(0, 15));
      r1 = 4'($urandom_range(0, 15));
      r2 = 4'($urandom_range(0, 15));
      if (k == 7) begin
        r1 = r0;
        r2 = r0;
      end
      c_ra = {r2, r1, r0};
      #1;
      e0 = (r0 == 0) ? 16'h0 : 16'hA000 + {12'h0, r0};
      e1 = (r1 == 0) ? 16'h0 : 16'hA000 + {12'h0, r1};
      e2 = (r2 == 0) ? 16'h0 : 16'hA000 + {12'h0, r2};
      check("c_rd0", c_rd[15:0], e0);
      check("c_rd1", c_rd[31:16], e1);
      check("c_rd2", c_rd[47:32], e2);
    end

    // Claim every register of C
    for (int n = 0; n < 16; n++) begin
      c_claim = 1; c_caddr = 4'(n);
      tick();
    end
    c_claim = 0; c_ra = {4'd5, 4'd5, 4'd0};
    #1;
    check("c_pc15", c_pc, 5'd15);
    check("c_bv", c_bv, 16'hFFFE);
    check("c_rdb", c_rdb, 3'b110);

    // Asynchronous reset mid-cycle with a write and claim pending
    #2;
    rst = 1'b1;
    a_we = 1; a_a3 = 5; a_wd = 32'hFFFF_FFFF; a_claim = 1; a_caddr = 5; a_ra = {5'd3, 5'd5};
    #1;
    check("arst_rd", a_rd, 64'h0);
    check("arst_rdb", a_rdb, 2'b00);
    check("arst_bv", a_bv, 32'h0);
    check("arst_pc", a_pc, 6'd0);
    check("arst_c_pc", c_pc, 5'd0);
    @(posedge clk);
    #2;
    a_we = 0; a_claim = 0;
    rst = 1'b0;
    c_ra = {4'd3, 4'd2, 4'd1};
    #1;
    check("post_rst_rd", a_rd, 64'h0);
    check("post_rst_bv", a_bv, 32'h0);
    check("post_rst_c_rd", c_rd, 48'h0);
    tick();
    check("post_rst_pc", a_pc, 6'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
